// File: rtl/button_gesture.sv
// button_gesture: turns debounced button level/pulses into click, double, long and repeat strobes.
// Optional auto-repeat while held long is built only when BUTTON_GESTURE_AUTO_REPEAT_EN is defined.

// state  | meaning
// IDLE   | no gesture in progress
// PRESS1 | first press held, timing LONG_MS
// WAIT2  | first press released, timing DBL_MS for a second press
// PRESS2 | second press held, timing LONG_MS
// LONG   | long press reported, waiting for release (and repeating, if built)
module button_gesture #(
  parameter int TICK_DIV  = 50000,
  parameter int LONG_MS   = 800,
  parameter int DBL_MS    = 300,
  parameter int REPEAT_MS = 150
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_state,
  input  logic       btn_down,
  input  logic       btn_up,
  output logic       evt_valid,
  output logic [1:0] evt_code,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, PRESS1, WAIT2, PRESS2, LONG} state_t;

  localparam logic [15:0] DIV_END  = 16'(TICK_DIV - 1);
  localparam logic [15:0] LONG_END = 16'(LONG_MS - 1);
  localparam logic [15:0] DBL_END  = 16'(DBL_MS - 1);

  if (TICK_DIV < 2 || TICK_DIV > 65535 || LONG_MS < 1 || LONG_MS > 65535 ||
      DBL_MS < 1 || DBL_MS > 65535 || REPEAT_MS < 1 || REPEAT_MS > 65535) begin : g_bad_param
    $error("button_gesture: parameter out of range");
  end

  state_t      state;
  logic [15:0] pre;
  logic [15:0] tcnt;
  logic [15:0] tcnt_inc;
  logic        tick;
  logic        fire_long;
  logic        fire_dbl;
  logic        release_seen;
  logic        press_seen;

  assign tick         = (pre == DIV_END);
  assign tcnt_inc     = (tick && tcnt != 16'hFFFF) ? tcnt + 16'd1 : tcnt;
  assign fire_long    = tick && (tcnt == LONG_END);
  assign fire_dbl     = tick && (tcnt == DBL_END);
  // a low level while pressed stands in for a lost btn_up pulse
  assign release_seen = btn_up || !btn_state;
  assign press_seen   = btn_down && !btn_up;

`ifdef BUTTON_GESTURE_AUTO_REPEAT_EN
  localparam logic [15:0] REP_END = 16'(REPEAT_MS - 1);
  logic fire_rep;
  assign fire_rep = tick && (tcnt == REP_END);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= 16'd0;
    end else if (tick) begin
      pre <= 16'd0;
    end else begin
      pre <= pre + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tcnt      <= 16'd0;
      evt_valid <= 1'b0;
      evt_code  <= 2'b00;
      busy      <= 1'b0;
    end else begin
      evt_valid <= 1'b0;
      tcnt      <= tcnt_inc;
      case (state)
        IDLE: begin
          if (press_seen) begin
            state <= PRESS1;
            tcnt  <= 16'd0;
            busy  <= 1'b1;
          end
        end
        PRESS1: begin
          if (release_seen) begin
            state <= WAIT2;
            tcnt  <= 16'd0;
          end else if (fire_long) begin
            state     <= LONG;
            tcnt      <= 16'd0;
            evt_valid <= 1'b1;
            evt_code  <= 2'b10;
          end
        end
        WAIT2: begin
          // any edge this cycle masks the double-click timeout
          if (press_seen) begin
            state <= PRESS2;
            tcnt  <= 16'd0;
          end else if (fire_dbl && !btn_up && !btn_down) begin
            state     <= IDLE;
            tcnt      <= 16'd0;
            busy      <= 1'b0;
            evt_valid <= 1'b1;
            evt_code  <= 2'b00;
          end
        end
        PRESS2: begin
          if (release_seen) begin
            state     <= IDLE;
            tcnt      <= 16'd0;
            busy      <= 1'b0;
            evt_valid <= 1'b1;
            evt_code  <= 2'b01;
          end else if (fire_long) begin
            state     <= LONG;
            tcnt      <= 16'd0;
            evt_valid <= 1'b1;
            evt_code  <= 2'b10;
          end
        end
        LONG: begin
          if (release_seen) begin
            state <= IDLE;
            tcnt  <= 16'd0;
            busy  <= 1'b0;
          end
`ifdef BUTTON_GESTURE_AUTO_REPEAT_EN
          else if (fire_rep) begin
            tcnt      <= 16'd0;
            evt_valid <= 1'b1;
            evt_code  <= 2'b11;
          end
`endif
        end
        default: begin
          state <= IDLE;
          tcnt  <= 16'd0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_gesture.sv
// Randomized and directed gesture scenarios checked against a gesture-level timing model.
module tb_button_gesture;

  localparam int TD  = 4;
  localparam int LMS = 10;
  localparam int DMS = 5;
  localparam int RMS = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_state = 1'b0;
  logic       btn_down = 1'b0;
  logic       btn_up = 1'b0;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // press list for one scenario, in edge indices counted from reset release
  int pd[$];
  int pu[$];
  bit pm[$];
  int exp_evt[$];
  int got_evt[$];
  int bz_lo[$];
  int bz_hi[$];

  always #5 clk = ~clk;

  button_gesture #(
    .TICK_DIV (TD),
    .LONG_MS  (LMS),
    .DBL_MS   (DMS),
    .REPEAT_MS(RMS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_state(btn_state),
    .btn_down (btn_down),
    .btn_up   (btn_up),
    .evt_valid(evt_valid),
    .evt_code (evt_code),
    .busy     (busy)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // edge index of the n-th timebase tick strictly after edge s
  function automatic int nth_tick(input int s, input int n);
    int e = s;
    int k = 0;
    while (k < n) begin
      e++;
      if (e % TD == TD - 1) k++;
    end
    return e;
  endfunction

  task automatic emit_long(input int tl, input int u);
    exp_evt.push_back(tl * 4 + 2);
`ifdef BUTTON_GESTURE_AUTO_REPEAT_EN
    begin
      int t = tl;
      int nx;
      forever begin
        nx = nth_tick(t, RMS);
        if (nx >= u) break;
        exp_evt.push_back(nx * 4 + 3);
        t = nx;
      end
    end
`endif
  endtask

  task automatic build_model();
    int i = 0;
    int n = pd.size();
    exp_evt.delete();
    bz_lo.delete();
    bz_hi.delete();
    while (i < n) begin
      int d1 = pd[i];
      int u1 = pu[i];
      int tl;
      int td;
      int endp;
      i++;
      tl = nth_tick(d1, LMS);
      if (tl < u1) begin
        emit_long(tl, u1);
        endp = u1;
      end else begin
        td = nth_tick(u1, DMS);
        if (i < n && pd[i] <= td) begin
          int d2 = pd[i];
          int u2 = pu[i];
          i++;
          tl = nth_tick(d2, LMS);
          if (tl < u2) emit_long(tl, u2);
          else exp_evt.push_back(u2 * 4 + 1);
          endp = u2;
        end else begin
          exp_evt.push_back(td * 4 + 0);
          endp = td;
        end
      end
      bz_lo.push_back(d1);
      bz_hi.push_back(endp);
    end
  endtask

  function automatic int exp_busy(input int e);
    for (int k = 0; k < bz_lo.size(); k++)
      if (bz_lo[k] <= e && e < bz_hi[k]) return 1;
    return 0;
  endfunction

  task automatic apply_reset();
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    btn_down = 1'b0;
    btn_up   = 1'b0;
    #1;
    check("rst_valid", int'(evt_valid), 0);
    check("rst_code", int'(evt_code), 0);
    check("rst_busy", int'(busy), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_scn(input string name, input int held_until);
    int last = 0;
    build_model();
    foreach (pu[k]) if (pu[k] > last) last = pu[k];
    foreach (bz_hi[k]) if (bz_hi[k] > last) last = bz_hi[k];
    last += 12;
    apply_reset();
    got_evt.delete();
    for (int e = 0; e <= last; e++) begin
      logic st;
      logic dn;
      logic up;
      st = (e < held_until);
      dn = 1'b0;
      up = (e == held_until);
      for (int k = 0; k < pd.size(); k++) begin
        if (e == pd[k]) dn = 1'b1;
        if (pd[k] <= e && e < pu[k]) st = 1'b1;
        if (e == pu[k] && !pm[k]) up = 1'b1;
      end
      btn_state = st;
      btn_down  = dn;
      btn_up    = up;
      @(posedge clk);
      #1;
      if (evt_valid) got_evt.push_back(e * 4 + int'(evt_code));
      check({name, ":busy"}, int'(busy), exp_busy(e));
    end
    btn_state = 1'b0;
    btn_down  = 1'b0;
    btn_up    = 1'b0;
    check({name, ":nevt"}, got_evt.size(), exp_evt.size());
    for (int k = 0; k < got_evt.size() && k < exp_evt.size(); k++)
      check({name, ":evt"}, got_evt[k], exp_evt[k]);
    if (exp_evt.size() > 0)
      check({name, ":held_code"}, int'(evt_code), exp_evt[exp_evt.size() - 1] % 4);
    pd.delete();
    pu.delete();
    pm.delete();
  endtask

  task automatic add_press(input int d, input int u, input bit miss);
    pd.push_back(d);
    pu.push_back(u);
    pm.push_back(miss);
  endtask

  initial begin
    int t;
    int td;

    // reset in the middle of a first press, button still held through reset
    apply_reset();
    for (int e = 0; e <= 20; e++) begin
      btn_down  = (e == 5);
      btn_state = (e >= 5);
      @(posedge clk);
      #1;
    end
    btn_down = 1'b0;
    check("pre_rst_busy", int'(busy), 1);
    add_press(10, 22, 1'b0);
    run_scn("reset", 2);

    add_press(5, 17, 1'b0);
    run_scn("click", -1);

    add_press(5, 13, 1'b0);
    add_press(21, 29, 1'b0);
    run_scn("double", -1);

    add_press(5, 53, 1'b0);
    run_scn("long", -1);

    add_press(5, 85, 1'b0);
    run_scn("long_hold20", -1);

    add_press(5, nth_tick(5, LMS), 1'b0);
    run_scn("race_long", -1);

    td = nth_tick(15, DMS);
    add_press(5, 15, 1'b0);
    add_press(td, td + 8, 1'b0);
    run_scn("race_dbl", -1);

    add_press(5, 17, 1'b1);
    run_scn("missed", -1);

    add_press(5, 60, 1'b1);
    run_scn("missed_long", -1);

    for (int s = 0; s < 30; s++) begin
      int n;
      n = $urandom_range(1, 4);
      t = $urandom_range(3, 12);
      for (int k = 0; k < n; k++) begin
        int hold;
        hold = $urandom_range(1, 56);
        add_press(t, t + hold, ($urandom_range(0, 3) == 0));
        t = t + hold + $urandom_range(1, 30);
      end
      run_scn("rand", -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
